// File: rtl/lcd_nibble_tx_if.sv
// Request/response and LCD pin bundle for the 4-bit HD44780-style nibble transmitter.
// The master drives transfer requests; the slave (the transmitter) drives status and pins.
interface lcd_nibble_tx_if;
  logic       start;
  logic [7:0] data;
  logic       rs;
  logic       nibble_only;
  logic       ready;
  logic       done;
  logic [3:0] lcd_db;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  modport master (
    output start, data, rs, nibble_only,
    input  ready, done, lcd_db, lcd_e, lcd_rs, lcd_rw
  );

  modport slave (
    input  start, data, rs, nibble_only,
    output ready, done, lcd_db, lcd_e, lcd_rs, lcd_rw
  );
endinterface

// File: rtl/lcd_nibble_tx.sv
// Sends one byte (or a single high nibble) to a character LCD over its 4-bit bus,
// sequencing setup/pulse/hold/gap/settle phases from a single shared cycle counter.
module lcd_nibble_tx #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 12,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned NIB_GAP_CYC = 50,
  parameter int unsigned SETTLE_CYC  = 2000,
  parameter int unsigned LONG_CYC    = 82000
) (
  input  logic           clk,
  input  logic           reset,
  lcd_nibble_tx_if.slave tx_if
);

  localparam int LONG_W   = $clog2(LONG_CYC + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int MAX_W    = (LONG_W > SETTLE_W) ? LONG_W : SETTLE_W;
  localparam int CNT_W    = (MAX_W > 17) ? MAX_W : 17;

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    NIB_GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    SETTLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;
  logic [3:0]       loNib_q;
  logic             rs_q;
  logic             nibbleOnly_q;
  logic             long_q;
  logic [3:0]       db_q, db_d;
  logic             e_q, e_d;
  logic             accept;
  logic             lastCyc;

  assign accept = (state_q == IDLE) && tx_if.start;

  always_comb begin
    limit = '0;
    case (state_q)
      HI_SETUP, LO_SETUP: limit = CNT_W'(SETUP_CYC - 1);
      HI_PULSE, LO_PULSE: limit = CNT_W'(PULSE_CYC - 1);
      HI_HOLD,  LO_HOLD:  limit = CNT_W'(HOLD_CYC - 1);
      NIB_GAP:            limit = CNT_W'(NIB_GAP_CYC - 1);
      SETTLE:             limit = long_q ? CNT_W'(LONG_CYC - 1) : CNT_W'(SETTLE_CYC - 1);
      default:            limit = '0;
    endcase
  end

  assign lastCyc = (cnt_q == limit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tx_if.start) state_d = HI_SETUP;
      HI_SETUP: if (lastCyc) state_d = HI_PULSE;
      HI_PULSE: if (lastCyc) state_d = HI_HOLD;
      HI_HOLD:  if (lastCyc) state_d = nibbleOnly_q ? SETTLE : NIB_GAP;
      NIB_GAP:  if (lastCyc) state_d = LO_SETUP;
      LO_SETUP: if (lastCyc) state_d = LO_PULSE;
      LO_PULSE: if (lastCyc) state_d = LO_HOLD;
      LO_HOLD:  if (lastCyc) state_d = SETTLE;
      SETTLE:   if (lastCyc) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change; E is registered from the next state so it
  // rises and falls exactly on pulse-state boundaries without combinational glitches.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    e_d  = (state_d == HI_PULSE) || (state_d == LO_PULSE);
    db_d = db_q;
    if (accept) begin
      db_d = tx_if.data[7:4];
    end else if ((state_q == NIB_GAP) && (state_d == LO_SETUP)) begin
      db_d = loNib_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      loNib_q      <= '0;
      rs_q         <= 1'b0;
      nibbleOnly_q <= 1'b0;
      long_q       <= 1'b0;
      db_q         <= '0;
      e_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      e_q     <= e_d;
      if (accept) begin
        loNib_q      <= tx_if.data[3:0];
        rs_q         <= tx_if.rs;
        nibbleOnly_q <= tx_if.nibble_only;
        long_q       <= !tx_if.rs && !tx_if.nibble_only &&
                        (tx_if.data inside {8'h01, 8'h02, 8'h03});
      end
    end
  end

  assign tx_if.ready  = (state_q == IDLE);
  assign tx_if.done   = (state_q == SETTLE) && lastCyc;
  assign tx_if.lcd_db = db_q;
  assign tx_if.lcd_e  = e_q;
  assign tx_if.lcd_rs = rs_q;
  assign tx_if.lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Directed bench for lcd_nibble_tx: latency, nibble values, gap, ignored starts,
// back-to-back transfers and mid-pulse reset, with a bus-timing monitor on every pulse.
module tb_lcd_nibble_tx;

  localparam int LONG_T   = 8200;
  localparam int FULL_LAT = 2080;
  localparam int NIB_LAT  = 2015;
  localparam int LONG_LAT = 8280;
  localparam int LO_GAP   = 53;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lcd_nibble_tx_if bus ();

  lcd_nibble_tx #(.LONG_CYC(LONG_T)) dut (
    .clk   (clk),
    .reset (reset),
    .tx_if (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Pulse monitor: history of the two previous samples gives setup stability at each rise.
  logic [3:0] pulseQ[$];
  int         lowQ[$];
  logic       prevE;
  int         highCnt;
  int         lowCnt;
  logic [3:0] dbH1, dbH2;
  logic       rsH1, rsH2;

  always @(negedge clk) begin
    if (reset) begin
      prevE   = 1'b0;
      highCnt = 0;
      lowCnt  = 0;
      dbH1    = bus.lcd_db;
      dbH2    = bus.lcd_db;
      rsH1    = bus.lcd_rs;
      rsH2    = bus.lcd_rs;
    end else begin
      if (bus.lcd_e && !prevE) begin
        checkOutput("setup_db", {24'd0, bus.lcd_db, bus.lcd_db}, {24'd0, dbH1, dbH2});
        checkOutput("setup_rs", {30'd0, bus.lcd_rs, bus.lcd_rs}, {30'd0, rsH1, rsH2});
        checkOutput("rw_low", {31'd0, bus.lcd_rw}, 32'd0);
        pulseQ.push_back(bus.lcd_db);
        lowQ.push_back(lowCnt);
        highCnt = 1;
      end else if (bus.lcd_e) begin
        highCnt++;
      end
      if (!bus.lcd_e && prevE) begin
        checkOutput("e_width", highCnt, 12);
        checkOutput("hold_db", {28'd0, bus.lcd_db}, {28'd0, dbH1});
        checkOutput("hold_rs", {31'd0, bus.lcd_rs}, {31'd0, rsH1});
        lowCnt = 1;
      end else if (!bus.lcd_e) begin
        lowCnt++;
      end
      prevE = bus.lcd_e;
      dbH2  = dbH1;
      dbH1  = bus.lcd_db;
      rsH2  = rsH1;
      rsH1  = bus.lcd_rs;
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic r, input logic nib);
    pulseQ.delete();
    lowQ.delete();
    @(negedge clk);
    for (int i = 0; i < 10 && !bus.ready; i++) @(negedge clk);
    bus.data        = d;
    bus.rs          = r;
    bus.nibble_only = nib;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.data        = ~d;
    bus.rs          = ~r;
    bus.nibble_only = ~nib;
  endtask

  task automatic waitDone(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 9000 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkPulses(input string tag, input int cnt, input logic [3:0] hi, input logic [3:0] lo);
    checkOutput({tag, "_pulses"}, pulseQ.size(), cnt);
    if (pulseQ.size() >= 1) checkOutput({tag, "_hi"}, {28'd0, pulseQ[0]}, {28'd0, hi});
    if (cnt == 2 && pulseQ.size() >= 2) begin
      checkOutput({tag, "_lo"}, {28'd0, pulseQ[1]}, {28'd0, lo});
      checkOutput({tag, "_gap"}, lowQ[1], LO_GAP);
    end
  endtask

  task automatic runTransfer(input string tag, input logic [7:0] d, input logic r,
                             input logic nib, input int expLat);
    int n;
    applyStimulus(d, r, nib);
    waitDone(n);
    checkOutput({tag, "_latency"}, n, expLat);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    checkOutput({tag, "_rs"}, {31'd0, bus.lcd_rs}, {31'd0, r});
    checkPulses(tag, nib ? 1 : 2, d[7:4], d[3:0]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int k;
    int doneCnt;
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.data        = 8'h00;
    bus.rs          = 1'b0;
    bus.nibble_only = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_e", {31'd0, bus.lcd_e}, 32'd0);
    checkOutput("rst_db", {28'd0, bus.lcd_db}, 32'd0);
    checkOutput("rst_rs", {31'd0, bus.lcd_rs}, 32'd0);
    checkOutput("rst_rw", {31'd0, bus.lcd_rw}, 32'd0);
    reset = 1'b0;

    runTransfer("byte28", 8'h28, 1'b0, 1'b0, FULL_LAT);
    checkOutput("byte28_db_after", {28'd0, bus.lcd_db}, 32'h8);
    runTransfer("nib30", 8'h30, 1'b0, 1'b1, NIB_LAT);
    runTransfer("clr_cmd", 8'h01, 1'b0, 1'b0, LONG_LAT);
    runTransfer("clr_data", 8'h01, 1'b1, 1'b0, FULL_LAT);
    runTransfer("nib02", 8'h02, 1'b0, 1'b1, NIB_LAT);
    runTransfer("cmd03", 8'h03, 1'b0, 1'b0, LONG_LAT);
    runTransfer("cmd04", 8'h04, 1'b0, 1'b0, FULL_LAT);

    // Starts during HI_PULSE and SETTLE must be dropped, not queued.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    fork
      waitDone(n);
      begin
        repeat (5) @(negedge clk);
        checkOutput("busy_ready", {31'd0, bus.ready}, 32'd0);
        bus.start = 1'b1;
        bus.data  = 8'h3C;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (150) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    checkOutput("ignore_latency", n, FULL_LAT);
    repeat (3) @(negedge clk);
    checkOutput("ignore_idle", {31'd0, bus.ready}, 32'd1);
    checkPulses("ignore", 2, 4'hA, 4'h5);

    // Start held high: second transfer accepted on the first IDLE cycle.
    pulseQ.delete();
    lowQ.delete();
    @(negedge clk);
    bus.data        = 8'h41;
    bus.rs          = 1'b1;
    bus.nibble_only = 1'b0;
    bus.start       = 1'b1;
    waitDone(n);
    checkOutput("b2b_first_latency", n, FULL_LAT);
    @(negedge clk);
    checkOutput("b2b_idle_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    checkOutput("b2b_second_busy", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b0;
    bus.data  = 8'h99;
    waitDone(k);
    checkOutput("b2b_second_latency", k + 1, FULL_LAT);
    checkOutput("b2b_pulses", pulseQ.size(), 4);
    if (pulseQ.size() == 4)
      checkOutput("b2b_values", {16'd0, pulseQ[0], pulseQ[1], pulseQ[2], pulseQ[3]}, 32'h4141);

    // Reset in the middle of the low-nibble pulse.
    @(negedge clk);
    applyStimulus(8'h28, 1'b0, 1'b0);
    repeat (70) @(negedge clk);
    checkOutput("pre_reset_e", {31'd0, bus.lcd_e}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_e_low", {31'd0, bus.lcd_e}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("post_reset_db", {28'd0, bus.lcd_db}, 32'd0);
    doneCnt = 0;
    repeat (2200) begin
      @(negedge clk);
      if (bus.done) doneCnt++;
    end
    checkOutput("post_reset_no_done", doneCnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_tx.md
LCD_NIBBLE_TX -- requirements
Module: lcd_nibble_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  SETUP_CYC      2      cycles DB/RS stable before E rises
  PULSE_CYC      12     cycles E held high
  HOLD_CYC       1      cycles DB/RS held after E falls
  NIB_GAP_CYC    50     cycles between high-nibble hold end and low-nibble setup start (1 us @ 50 MHz)
  SETTLE_CYC     2000   post-transfer wait, normal command/data (40 us)
  LONG_CYC       82000  post-transfer wait, clear/home (1.64 ms)
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk          in   1  system clock, 50 MHz, rising edge
  reset        in   1  asynchronous, active-high
  start        in   1  request transfer; sampled only when ready=1
  data         in   8  byte to send; data[7:4] only for nibble-only transfers
  rs           in   1  register select for this transfer (0 = command, 1 = data)
  nibble_only  in   1  1 = send data[7:4] only (init-sequence writes)
  ready        out  1  1 = idle, start will be accepted
  done         out  1  one-cycle pulse at transfer completion
  lcd_db       out  4  LCD data bus DB[7:4]
  lcd_e        out  1  LCD enable strobe
  lcd_rs       out  1  LCD register select
  lcd_rw       out  1  LCD read/write, constant 0

Function
REQ-003 The block SHALL feed the LCD 4-bit bus for both the power-on init sequencer and the runtime command/data sequencer; all timing comes from one internal down/up counter, at least 17 bits wide.
REQ-004 States: IDLE, HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP, LO_SETUP, LO_PULSE, LO_HOLD, SETTLE.
REQ-005 Each timed state SHALL last exactly its parameter count of cycles: counter starts at 0 on entry and the state exits when counter = N-1; the counter SHALL clear on every state change.
REQ-006 In IDLE with start=1, the block SHALL capture data, rs, nibble_only and a long flag, and enter HI_SETUP on the next edge; long = (rs=0 and nibble_only=0 and data in {0x01, 0x02, 0x03}).
REQ-007 Transitions: HI_SETUP->HI_PULSE->HI_HOLD; then NIB_GAP if nibble_only=0, else SETTLE. NIB_GAP->LO_SETUP->LO_PULSE->LO_HOLD->SETTLE->IDLE.
REQ-008 SETTLE SHALL last LONG_CYC when long=1, otherwise SETTLE_CYC.
REQ-009 lcd_db SHALL be registered: captured data[7:4] from HI_SETUP entry, data[3:0] from LO_SETUP entry, held unchanged until the next update.
REQ-010 lcd_e SHALL be registered, high exactly during HI_PULSE and LO_PULSE cycles, glitch-free, low at all other times.
REQ-011 lcd_rs SHALL equal the captured rs from HI_SETUP entry until the next accepted start.
REQ-012 lcd_rw SHALL be 0 at all times.
REQ-013 ready SHALL be 1 only in IDLE; start in any other state SHALL be ignored, with no queuing.
REQ-014 done SHALL be 1 for exactly the final SETTLE cycle; ready rises on the following cycle.
REQ-015 Latency from the accepting edge to done, inclusive: full byte 2080 cycles, nibble-only 2015, long command 82080 (default parameters).
REQ-016 start held high continuously SHALL produce back-to-back transfers, each accepted on the first IDLE cycle.
REQ-017 Changes on data, rs or nibble_only after acceptance SHALL NOT affect the transfer in progress.

Reset
REQ-018 While reset=1: state=IDLE, counter=0, lcd_e=0, lcd_db=0, lcd_rs=0, lcd_rw=0, done=0, ready=1.
REQ-019 Reset asserted mid-transfer, including mid E pulse, SHALL force lcd_e low immediately (asynchronous) and abort the transfer; no done pulse SHALL be issued.

Verification
REQ-020 Byte 0x28, rs=0 -> DB=0x2 with E high for 12 cycles, 50-cycle gap, DB=0x8 with E high for 12 cycles, done 2080 cycles after accept.
REQ-021 nibble_only=1, data=0x30 -> single E pulse with DB=0x3, done 2015 cycles after accept; no second pulse.
REQ-022 Byte 0x01, rs=0 -> done 82080 cycles after accept; the same byte with rs=1 -> done at 2080.
REQ-023 Pulse start during HI_PULSE and SETTLE with different data -> ignored; bus carries only the original byte; start held high -> second transfer begins on the first IDLE cycle.
REQ-024 Assert reset during LO_PULSE -> lcd_e=0 in the same cycle; after release ready=1, lcd_db=0, no done pulse.
REQ-025 Checker on all tests: lcd_db and lcd_rs stable for 2 cycles before each E rise and 1 cycle after each E fall; lcd_rw never 1.
